frame_config_sequencer: RTL and testbench
=========================================

# frame_config_sequencer

Sequences writes into the frame-based configuration memory of a fabric column array. It accepts a word stream over a valid/ready handshake, loads one 32-bit word per tile row onto the per-row FrameData buses, then pulses the FrameStrobe line for the addressed column/frame. It sits between the bitstream source (UART/SPI loader) and the tile FrameData/FrameStrobe inputs. It replaces open-coded strobe generation in the top level.

## Interface
Parameters:
- FrameBitsPerRow, 32, bits per FrameData word per row
- MaxFramesPerCol, 20, strobe lines per column
- NumberOfRows, 16, tile rows loaded per frame
- NumberOfCols, 8, columns addressable
- StrobeCycles, 2, FrameStrobe high time in cycles (≥1)

Ports:
- UserCLK  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- s_data  in  FrameBitsPerRow  stream word
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid&&s_ready
- FrameData  out  NumberOfRows*FrameBitsPerRow  row r at slice [r*FrameBitsPerRow +: FrameBitsPerRow]
- FrameStrobe  out  NumberOfCols*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
- frame_done  out  1  one-cycle pulse per committed frame
- err_header  out  1  one-cycle pulse on rejected header
- err_parity  out  1  one-cycle pulse on trailer mismatch (FRAME_CFG_PARITY_EN only; tied 0 otherwise)

## Operation
- Header word: [31:28] marker 4'hA; [27:20] column; [19:15] frame; [14:0] ignored.
- States: IDLE, DATA, (TRAILER), STROBE, HOLD.
- IDLE: s_ready=1. Accepted word with a bad marker → err_header, stay in IDLE. A valid marker with column≥NumberOfCols or frame≥MaxFramesPerCol → err_header, enter DATA with a discard flag set. Otherwise latch column/frame, enter DATA, row_cnt=0.
- DATA: s_ready=1. Each accepted word → FrameData row[row_cnt] (unless discarding), row_cnt++. Words with a marker-looking top nibble are treated as data. After row NumberOfRows-1 → TRAILER if enabled, else STROBE (discard → IDLE, no strobe, no frame_done).
- STROBE: s_ready=0. Exactly one FrameStrobe bit is high for StrobeCycles cycles. frame_done is asserted in the last strobe cycle. Then → HOLD.
- HOLD: s_ready=0, strobes 0 for one cycle (data hold after strobe fall). Then → IDLE.
- FrameData holds its last written value until overwritten. It is never cleared except by reset.
- At most one FrameStrobe bit is high at any time.

## Timing
- Reset values: s_ready=0 while resetn low, 1 in the first cycle after release. FrameData=0, FrameStrobe=0, all pulses 0, state IDLE, row_cnt=0.
- Reset mid-frame: everything clears asynchronously, FrameStrobe drops immediately, and the partial frame is discarded.
- FrameData row updates on the edge that accepts its word. Strobe rises on the edge after the last data word (or trailer) is accepted, so data is stable ≥1 cycle before the strobe rises.
- Back-to-back frames: minimum 1 header + NumberOfRows (+1) + StrobeCycles + 1 cycles per frame.
- row_cnt width is $clog2(NumberOfRows). It wraps only via the state transition, never arithmetically.

## Configuration
- FRAME_CFG_PARITY_EN defined: after the last row, a TRAILER state accepts one word that must equal the XOR of all NumberOfRows data words.
  - Match → STROBE.
  - Mismatch → err_parity pulse, → IDLE. Rows already written stay on FrameData, but no strobe is issued.
- FRAME_CFG_PARITY_EN undefined: there is no TRAILER state, no XOR accumulator, and err_parity is tied 0.

## Structure
- Package frame_cfg_pkg holds:
  - state enum
  - HDR_MARKER=4'hA
  - header field LSB/MSB constants
- Sub-module frame_strobe_decoder: combinational decode of (column, frame, enable) into the one-hot FrameStrobe vector.

## Test plan
- Header 32'hA0308000 (col 3, frame 1), then 16 words 32'h1000_0000+r → FrameData row r = 32'h1000_000r, FrameStrobe bit 61 high for 2 cycles, one frame_done, s_ready low for 3 cycles.
- Header 32'h5000_0000 → err_header pulse, stays IDLE, no strobe. Next valid frame commits normally.
- Header with col 9 (≥8) plus 16 words → err_header, FrameData unchanged, no strobe, ready for the next header.
- resetn low during row 7 → FrameData=0 and FrameStrobe=0 immediately. After release a full frame commits correctly.
- s_valid toggled randomly (50%) across a frame → same FrameData/strobe result as the back-to-back case.
- With FRAME_CFG_PARITY_EN: correct XOR trailer → strobe; trailer XOR^1 → err_parity, no strobe, returns to IDLE.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// -----------------------------------------------------------------------------
// frame_cfg_pkg
// Shared definitions for the frame configuration sequencer:
//   - sequencer state encoding
//   - header marker value and header field bit positions
// -----------------------------------------------------------------------------
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_TRAILER = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [3:0] HDR_MARKER = 4'hA;

    localparam int HDR_MARKER_MSB = 31;
    localparam int HDR_MARKER_LSB = 28;
    localparam int HDR_COL_MSB    = 27;
    localparam int HDR_COL_LSB    = 20;
    localparam int HDR_FRAME_MSB  = 19;
    localparam int HDR_FRAME_LSB  = 15;

    localparam int HDR_COL_W   = HDR_COL_MSB - HDR_COL_LSB + 1;
    localparam int HDR_FRAME_W = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// -----------------------------------------------------------------------------
// frame_strobe_decoder
// Combinational one-hot decode of (column, frame, enable) onto the flat
// FrameStrobe vector. Bit c*MaxFramesPerCol+f is high when enable is set and
// the inputs address column c, frame f. Out-of-range addresses decode to 0.
//
// Ports:
//   column  in  HDR_COL_W    column address
//   frame   in  HDR_FRAME_W  frame address within the column
//   enable  in  1            strobe enable
//   strobe  out NumberOfCols*MaxFramesPerCol  one-hot strobe vector
// -----------------------------------------------------------------------------
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 8
) (
    input  logic [HDR_COL_W-1:0]                    column,
    input  logic [HDR_FRAME_W-1:0]                  frame,
    input  logic                                    enable,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

    for (genvar c = 0; c < NumberOfCols; c++) begin : g_col
        for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
            assign strobe[c*MaxFramesPerCol+f] = enable
                                              && (column == HDR_COL_W'(c))
                                              && (frame == HDR_FRAME_W'(f));
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// -----------------------------------------------------------------------------
// frame_config_sequencer
// Takes a header + per-row word stream over valid/ready, loads one word per
// tile row onto FrameData, then pulses the FrameStrobe bit of the addressed
// column/frame for StrobeCycles cycles, followed by one hold cycle.
//
// Optional feature macro: FRAME_CFG_PARITY_EN
//   When defined, a trailer word equal to the XOR of all row words must follow
//   the last row; a mismatch raises err_parity and suppresses the strobe.
//
// Ports:
//   UserCLK      in   clock
//   resetn       in   asynchronous active-low reset
//   s_data       in   stream word (header, row data, trailer)
//   s_valid      in   stream word valid
//   s_ready      out  stream ready (word taken when s_valid && s_ready)
//   FrameData    out  row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  out  column c, frame f at bit c*MaxFramesPerCol+f
//   frame_done   out  pulse in the last strobe cycle of a committed frame
//   err_header   out  pulse after a rejected header
//   err_parity   out  pulse after a trailer mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 8,
    parameter int StrobeCycles    = 2
) (
    input  logic                                    UserCLK,
    input  logic                                    resetn,
    input  logic [FrameBitsPerRow-1:0]              s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    frame_done,
    output logic                                    err_header,
    output logic                                    err_parity
);

    localparam int RCW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int SCW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [RCW-1:0] LAST_ROW = RCW'(NumberOfRows - 1);
    localparam logic [SCW-1:0] LAST_STB = SCW'(StrobeCycles - 1);

    state_t                       state, state_nxt;
    logic [RCW-1:0]               row_cnt;
    logic [SCW-1:0]               strb_cnt;
    logic [HDR_COL_W-1:0]         col_q;
    logic [HDR_FRAME_W-1:0]       frame_q;
    logic                         discard_q;
    logic                         err_header_q;
    logic [FrameBitsPerRow-1:0]   rows_q [NumberOfRows];

`ifdef FRAME_CFG_PARITY_EN
    logic [FrameBitsPerRow-1:0]   xor_acc;
    logic                         err_parity_q;
`endif

    logic                         accept;
    logic                         marker_ok;
    logic                         range_ok;
    logic [HDR_COL_W-1:0]         hdr_col;
    logic [HDR_FRAME_W-1:0]       hdr_frame;

    assign hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign hdr_frame = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign marker_ok = (s_data[HDR_MARKER_MSB:HDR_MARKER_LSB] == HDR_MARKER);
    assign range_ok  = (32'(hdr_col) < NumberOfCols) && (32'(hdr_frame) < MaxFramesPerCol);

    // Gated by resetn directly so ready is low for the whole reset assertion
    // and rises as soon as reset is released.
    assign s_ready = resetn && ((state == ST_IDLE) || (state == ST_DATA)
                                || (state == ST_TRAILER));
    assign accept  = s_valid && s_ready;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && marker_ok) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (accept && (row_cnt == LAST_ROW)) begin
`ifdef FRAME_CFG_PARITY_EN
                    state_nxt = ST_TRAILER;
`else
                    state_nxt = discard_q ? ST_IDLE : ST_STROBE;
`endif
                end
            end
`ifdef FRAME_CFG_PARITY_EN
            ST_TRAILER: begin
                // A discarded frame still consumes its trailer to keep the
                // stream aligned, but never strobes.
                if (accept) begin
                    state_nxt = (!discard_q && (s_data == xor_acc)) ? ST_STROBE : ST_IDLE;
                end
            end
`endif
            ST_STROBE: begin
                if (strb_cnt == LAST_STB) state_nxt = ST_HOLD;
            end
            ST_HOLD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, latched address and row data
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            row_cnt      <= '0;
            strb_cnt     <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            discard_q    <= 1'b0;
            err_header_q <= 1'b0;
            for (int r = 0; r < NumberOfRows; r++) rows_q[r] <= '0;
`ifdef FRAME_CFG_PARITY_EN
            xor_acc      <= '0;
            err_parity_q <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            err_header_q <= 1'b0;
`ifdef FRAME_CFG_PARITY_EN
            err_parity_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!marker_ok) begin
                            err_header_q <= 1'b1;
                        end else begin
                            col_q        <= hdr_col;
                            frame_q      <= hdr_frame;
                            discard_q    <= !range_ok;
                            err_header_q <= !range_ok;
                            row_cnt      <= '0;
`ifdef FRAME_CFG_PARITY_EN
                            xor_acc      <= '0;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (!discard_q) rows_q[row_cnt] <= s_data;
`ifdef FRAME_CFG_PARITY_EN
                        xor_acc <= xor_acc ^ s_data;
`endif
                        // Wrap is tied to leaving DATA, not to counter overflow.
                        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                    end
                end
`ifdef FRAME_CFG_PARITY_EN
                ST_TRAILER: begin
                    if (accept && !discard_q && (s_data != xor_acc)) err_parity_q <= 1'b1;
                end
`endif
                ST_STROBE: begin
                    strb_cnt <= (strb_cnt == LAST_STB) ? '0 : strb_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar r = 0; r < NumberOfRows; r++) begin : g_row
        assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
    end

    // Strobe decode straight from registered state, so reset drops it at once.
    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumberOfCols    (NumberOfCols)
    ) u_decoder (
        .column (col_q),
        .frame  (frame_q),
        .enable (state == ST_STROBE),
        .strobe (FrameStrobe)
    );

    assign frame_done = (state == ST_STROBE) && (strb_cnt == LAST_STB);
    assign err_header = err_header_q;

`ifdef FRAME_CFG_PARITY_EN
    assign err_parity = err_parity_q;
`else
    assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_frame_config_sequencer.sv
module tb_frame_config_sequencer;

    localparam int FB = 32;
    localparam int MF = 20;
    localparam int NR = 16;
    localparam int NC = 8;
    localparam int SC = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [FB-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [NR*FB-1:0]  FrameData;
    logic [NC*MF-1:0]  FrameStrobe;
    logic              frame_done;
    logic              err_header;
    logic              err_parity;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int done_cnt = 0;
    int hdr_err_cnt = 0;
    int par_err_cnt = 0;
    int strobe_cyc = 0;
    int onehot_viol = 0;

    always #5 clk = ~clk;

    frame_config_sequencer #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .NumberOfRows    (NR),
        .NumberOfCols    (NC),
        .StrobeCycles    (SC)
    ) dut (
        .UserCLK     (clk),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .frame_done  (frame_done),
        .err_header  (err_header),
        .err_parity  (err_parity)
    );

    always @(posedge clk) begin
        cyc++;
        if (frame_done === 1'b1) done_cnt++;
        if (err_header === 1'b1) hdr_err_cnt++;
        if (err_parity === 1'b1) par_err_cnt++;
        if (FrameStrobe != '0) strobe_cyc++;
        if ($countones(FrameStrobe) > 1) onehot_viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [NC*MF-1:0] one_bit(input int idx);
        logic [NC*MF-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        hdr_err_cnt = 0;
        par_err_cnt = 0;
        strobe_cyc = 0;
    endtask

    task automatic send_word(input logic [FB-1:0] w, input bit rnd);
        int n;
        if (rnd) begin
            s_valid = 1'b0;
            for (int k = 0; k < 6 && $urandom_range(0, 1) == 0; k++) cycle();
        end
        s_data  = w;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_word_ready_timeout got=%b want=1", s_ready);
        end
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [FB-1:0] hdr, input logic [FB-1:0] base,
                              input bit rnd, input bit bad_trailer);
        logic [FB-1:0] acc;
        acc = '0;
        send_word(hdr, rnd);
        for (int r = 0; r < NR; r++) begin
            acc ^= base + FB'(r);
            send_word(base + FB'(r), rnd);
        end
`ifdef FRAME_CFG_PARITY_EN
        send_word(bad_trailer ? (acc ^ 32'h1) : acc, rnd);
`else
        if (bad_trailer) acc = '0;
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) cycle();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", s_ready); end
        total++; if (FrameData !== '0) begin bad++; $display("FAIL reset_framedata got=%h want=0", FrameData); end
        total++; if (FrameStrobe !== '0) begin bad++; $display("FAIL reset_strobe got=%h want=0", FrameStrobe); end
        total++; if ({frame_done, err_header, err_parity} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses got=%b want=000", {frame_done, err_header, err_parity});
        end
        resetn = 1'b1;
        cycle();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_basic();
        logic [NC*MF-1:0] exp;
        exp = one_bit(3*MF + 1);
        clear_counts();
        send_frame(32'hA030_8000, 32'h1000_0000, 1'b0, 1'b0);
        total++; if (FrameStrobe !== exp) begin bad++; $display("FAIL basic_strobe_c0 got=%h want=%h", FrameStrobe, exp); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_c0 got=%b want=0", frame_done); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_c0 got=%b want=0", s_ready); end
        for (int r = 0; r < NR; r++) begin
            total++;
            if (FrameData[r*FB +: FB] !== 32'h1000_0000 + r) begin
                bad++; $display("FAIL basic_row%0d got=%h want=%h", r, FrameData[r*FB +: FB], 32'h1000_0000 + r);
            end
        end
        cycle();
        total++; if (FrameStrobe !== exp) begin bad++; $display("FAIL basic_strobe_c1 got=%h want=%h", FrameStrobe, exp); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL basic_done_c1 got=%b want=1", frame_done); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_c1 got=%b want=0", s_ready); end
        cycle();
        total++; if (FrameStrobe !== '0) begin bad++; $display("FAIL basic_strobe_hold got=%h want=0", FrameStrobe); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_hold got=%b want=0", frame_done); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_hold got=%b want=0", s_ready); end
        cycle();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_idle got=%b want=1", s_ready); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
        total++; if (strobe_cyc !== SC) begin bad++; $display("FAIL basic_strobe_cycles got=%0d want=%0d", strobe_cyc, SC); end
    endtask

    task automatic test_bad_marker();
        clear_counts();
        send_word(32'h5000_0000, 1'b0);
        total++; if (err_header !== 1'b1) begin bad++; $display("FAIL marker_err got=%b want=1", err_header); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL marker_ready got=%b want=1", s_ready); end
        cycle();
        total++; if (err_header !== 1'b0) begin bad++; $display("FAIL marker_err_pulse got=%b want=0", err_header); end
        send_frame(32'hA000_0000, 32'h2000_0000, 1'b0, 1'b0);
        total++; if (FrameStrobe !== one_bit(0)) begin bad++; $display("FAIL marker_next_strobe got=%h want=%h", FrameStrobe, one_bit(0)); end
        for (int r = 0; r < NR; r++) begin
            total++;
            if (FrameData[r*FB +: FB] !== 32'h2000_0000 + r) begin
                bad++; $display("FAIL marker_next_row%0d got=%h want=%h", r, FrameData[r*FB +: FB], 32'h2000_0000 + r);
            end
        end
        repeat (3) cycle();
        total++; if (hdr_err_cnt !== 1) begin bad++; $display("FAIL marker_err_count got=%0d want=1", hdr_err_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL marker_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_bad_range();
        clear_counts();
        send_word(32'hA090_0000, 1'b0);
        total++; if (err_header !== 1'b1) begin bad++; $display("FAIL range_col_err got=%b want=1", err_header); end
        for (int r = 0; r < NR; r++) send_word(32'hDEAD_0000 + FB'(r), 1'b0);
`ifdef FRAME_CFG_PARITY_EN
        send_word(32'h0, 1'b0);
`endif
        repeat (3) cycle();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL range_col_ready got=%b want=1", s_ready); end
        for (int r = 0; r < NR; r++) begin
            total++;
            if (FrameData[r*FB +: FB] !== 32'h2000_0000 + r) begin
                bad++; $display("FAIL range_col_row%0d got=%h want=%h", r, FrameData[r*FB +: FB], 32'h2000_0000 + r);
            end
        end
        send_frame(32'hA00A_0000, 32'hBEEF_0000, 1'b0, 1'b0);
        repeat (3) cycle();
        total++; if (hdr_err_cnt !== 2) begin bad++; $display("FAIL range_err_count got=%0d want=2", hdr_err_cnt); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL range_done_count got=%0d want=0", done_cnt); end
        total++; if (strobe_cyc !== 0) begin bad++; $display("FAIL range_strobe_cycles got=%0d want=0", strobe_cyc); end
        total++; if (FrameData[0 +: FB] !== 32'h2000_0000) begin bad++; $display("FAIL range_frame_row0 got=%h want=20000000", FrameData[0 +: FB]); end
    endtask

    task automatic test_reset_mid_frame();
        send_word(32'hA030_8000, 1'b0);
        for (int r = 0; r < 7; r++) send_word(32'h5000_0000 + FB'(r), 1'b0);
        s_data  = 32'h5000_0007;
        s_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        total++; if (FrameData !== '0) begin bad++; $display("FAIL midrst_framedata got=%h want=0", FrameData); end
        total++; if (FrameStrobe !== '0) begin bad++; $display("FAIL midrst_strobe got=%h want=0", FrameStrobe); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", s_ready); end
        s_valid = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        // Reset while the strobe is high must drop it without waiting for an edge.
        send_frame(32'hA030_8000, 32'h6000_0000, 1'b0, 1'b0);
        total++; if (FrameStrobe !== one_bit(61)) begin bad++; $display("FAIL strbrst_pre got=%h want=%h", FrameStrobe, one_bit(61)); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (FrameStrobe !== '0) begin bad++; $display("FAIL strbrst_strobe got=%h want=0", FrameStrobe); end
        total++; if (FrameData !== '0) begin bad++; $display("FAIL strbrst_framedata got=%h want=0", FrameData); end
        cycle();
        resetn = 1'b1;
        cycle();
        clear_counts();
        send_frame(32'hA030_8000, 32'h3000_0000, 1'b0, 1'b0);
        total++; if (FrameStrobe !== one_bit(61)) begin bad++; $display("FAIL midrst_after_strobe got=%h want=%h", FrameStrobe, one_bit(61)); end
        for (int r = 0; r < NR; r++) begin
            total++;
            if (FrameData[r*FB +: FB] !== 32'h3000_0000 + r) begin
                bad++; $display("FAIL midrst_after_row%0d got=%h want=%h", r, FrameData[r*FB +: FB], 32'h3000_0000 + r);
            end
        end
        repeat (3) cycle();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_random_valid();
        clear_counts();
        send_frame(32'hA079_8000, 32'h4000_0000, 1'b1, 1'b0);
        total++; if (FrameStrobe !== one_bit(7*MF + 19)) begin
            bad++; $display("FAIL rand_strobe got=%h want=%h", FrameStrobe, one_bit(7*MF + 19));
        end
        for (int r = 0; r < NR; r++) begin
            total++;
            if (FrameData[r*FB +: FB] !== 32'h4000_0000 + r) begin
                bad++; $display("FAIL rand_row%0d got=%h want=%h", r, FrameData[r*FB +: FB], 32'h4000_0000 + r);
            end
        end
        repeat (3) cycle();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand_done_count got=%0d want=1", done_cnt); end
        total++; if (strobe_cyc !== SC) begin bad++; $display("FAIL rand_strobe_cycles got=%0d want=%0d", strobe_cyc, SC); end
    endtask

    task automatic test_back_to_back();
        int c0;
        int want;
`ifdef FRAME_CFG_PARITY_EN
        want = 1 + (1 + NR + 1 + SC + 1) + NR + 1;
`else
        want = 1 + (1 + NR + SC + 1) + NR;
`endif
        clear_counts();
        c0 = cyc;
        send_frame(32'hA010_0000, 32'h8000_0000, 1'b0, 1'b0);
        send_frame(32'hA020_0000, 32'h9000_0000, 1'b0, 1'b0);
        total++; if (cyc - c0 !== want) begin bad++; $display("FAIL b2b_cycles got=%0d want=%0d", cyc - c0, want); end
        total++; if (FrameStrobe !== one_bit(2*MF)) begin bad++; $display("FAIL b2b_strobe got=%h want=%h", FrameStrobe, one_bit(2*MF)); end
        total++; if (FrameData[(NR-1)*FB +: FB] !== 32'h9000_000F) begin
            bad++; $display("FAIL b2b_last_row got=%h want=9000000f", FrameData[(NR-1)*FB +: FB]);
        end
        repeat (3) cycle();
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt); end
    endtask

`ifdef FRAME_CFG_PARITY_EN
    task automatic test_parity();
        clear_counts();
        send_frame(32'hA022_8000, 32'h7000_0000, 1'b0, 1'b0);
        total++; if (FrameStrobe !== one_bit(2*MF + 5)) begin bad++; $display("FAIL par_good_strobe got=%h want=%h", FrameStrobe, one_bit(2*MF + 5)); end
        repeat (3) cycle();
        send_frame(32'hA022_8000, 32'h7100_0000, 1'b0, 1'b1);
        total++; if (err_parity !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b want=1", err_parity); end
        total++; if (FrameStrobe !== '0) begin bad++; $display("FAIL par_bad_strobe got=%h want=0", FrameStrobe); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL par_bad_ready got=%b want=1", s_ready); end
        total++; if (FrameData[3*FB +: FB] !== 32'h7100_0003) begin bad++; $display("FAIL par_bad_row3 got=%h want=71000003", FrameData[3*FB +: FB]); end
        repeat (3) cycle();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL par_done_count got=%0d want=1", done_cnt); end
        total++; if (par_err_cnt !== 1) begin bad++; $display("FAIL par_err_count got=%0d want=1", par_err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_marker();
        test_bad_range();
        test_reset_mid_frame();
        test_random_valid();
        test_back_to_back();
`ifdef FRAME_CFG_PARITY_EN
        test_parity();
`else
        total++; if (par_err_cnt !== 0) begin bad++; $display("FAIL parity_tied got=%0d want=0", par_err_cnt); end
`endif
        total++; if (onehot_viol !== 0) begin bad++; $display("FAIL strobe_onehot got=%0d want=0", onehot_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
